// File: rtl/rv_mem_arb.sv
// Two-requester arbiter that shares one single-port, variable-latency memory
// between the instruction-fetch port and the data port of the multicycle core.
module rv_mem_arb #(
  parameter int DPWIDTH = 32,
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [DPWIDTH-1:0] i_addr,
  output logic               i_ack,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [DPWIDTH-1:0] d_addr,
  input  logic [DPWIDTH-1:0] d_wdata,
  output logic               d_ack,
  output logic [DPWIDTH-1:0] rdata,
  output logic               err,
  output logic               m_req,
  output logic               m_we,
  output logic [DPWIDTH-1:0] m_addr,
  output logic [DPWIDTH-1:0] m_wdata,
  input  logic [DPWIDTH-1:0] m_rdata,
  input  logic               m_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNTW-1:0] TMAX    = TLIM[CNTW-1:0];
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_t             state, state_nxt;
  logic               owner_d;
  logic               last_d;
  logic               lat_we;
  logic [DPWIDTH-1:0] lat_addr;
  logic [DPWIDTH-1:0] lat_wdata;
  logic [CNTW-1:0]    cnt;
  logic               any_req;
  logic               grant_d;
  logic               timeout_hit;

  // Under contention the port that did not win last time gets the grant.
  assign any_req     = i_req | d_req;
  assign grant_d     = d_req & ~(i_req & last_d);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == TMAX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (m_ack || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // m_ack is tested before the timeout so a late completion is never reported as an error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      last_d    <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_d   <= grant_d;
            last_d    <= grant_d;
            lat_we    <= grant_d & d_we;
            lat_addr  <= grant_d ? d_addr : i_addr;
            lat_wdata <= grant_d ? d_wdata : '0;
            cnt       <= '0;
          end
        end
        BUSY: begin
          if (m_ack) begin
            rdata <= lat_we ? '0 : m_rdata;
            err   <= 1'b0;
          end else if (timeout_hit) begin
            rdata <= '0;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_req   = (state == BUSY);
  assign m_we    = m_req & lat_we;
  assign m_addr  = m_req ? lat_addr : '0;
  assign m_wdata = m_req ? lat_wdata : '0;
  assign i_ack   = (state == RESP) & ~owner_d;
  assign d_ack   = (state == RESP) & owner_d;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Scoreboard bench for rv_mem_arb: directed accesses push expected grants and
// responses; a negedge monitor checks the memory side and every ack against them.
module tb_rv_mem_arb;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] mrd;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_busy;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] rdata;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = 32'hBAD0BAD0;
  logic        m_ack = 1'b0;

  bit   force_ack = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   bcnt = 0;
  int   busy_seen = 0;
  txn_t exp_q[$];
  txn_t i_pend[$];
  txn_t d_pend[$];
  txn_t mon_t;

  always #5 clk = ~clk;

  rv_mem_arb #(.DPWIDTH(32), .TIMEOUT(4), .CNTW(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .err(err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit is_d, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input int lat, input logic [31:0] mrd,
                               input logic [31:0] exp_rdata, input bit exp_err, input int exp_busy);
    txn_t t;
    t.is_d = is_d; t.we = we; t.addr = addr; t.wdata = wdata; t.lat = lat; t.mrd = mrd;
    t.exp_rdata = exp_rdata; t.exp_err = exp_err; t.exp_busy = exp_busy;
    exp_q.push_back(t);
    if (is_d) d_pend.push_back(t);
    else i_pend.push_back(t);
  endtask

  task automatic waitDone(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_done: got %0d outstanding accesses, expected 0", exp_q.size());
      exp_q.delete();
      i_pend.delete();
      d_pend.delete();
    end
  endtask

  // Requesters hold their request until acked, then move to the next queued access.
  always @(negedge clk) begin
    if (i_ack && i_pend.size() > 0) i_pend.delete(0);
    if (d_ack && d_pend.size() > 0) d_pend.delete(0);
    i_req   = (i_pend.size() > 0);
    i_addr  = (i_pend.size() > 0) ? i_pend[0].addr : 32'h0;
    d_req   = (d_pend.size() > 0);
    d_we    = (d_pend.size() > 0) ? d_pend[0].we : 1'b0;
    d_addr  = (d_pend.size() > 0) ? d_pend[0].addr : 32'h0;
    d_wdata = (d_pend.size() > 0) ? d_pend[0].wdata : 32'h0;
  end

  // Memory model: acks in the lat-th BUSY cycle of the current access (lat 0 never acks).
  always @(negedge clk) begin
    if (m_req) begin
      bcnt++;
      if (exp_q.size() > 0 && exp_q[0].lat != 0 && bcnt == exp_q[0].lat) begin
        m_ack   = 1'b1;
        m_rdata = exp_q[0].mrd;
      end else begin
        m_ack   = 1'b0;
        m_rdata = 32'hBAD0BAD0;
      end
    end else begin
      bcnt    = 0;
      m_ack   = force_ack;
      m_rdata = force_ack ? 32'h0BADCAFE : 32'hBAD0BAD0;
    end
  end

  always @(negedge clk) begin
    if (m_req) begin
      busy_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_m_req: got m_addr %h, expected no access", m_addr);
      end else begin
        checkOutput("m_addr", m_addr, exp_q[0].addr);
        checkOutput("m_we", 32'(m_we), 32'(exp_q[0].we));
        checkOutput("m_wdata", m_wdata, exp_q[0].wdata);
      end
    end
    if (i_ack || d_ack) begin
      checkOutput("ack_overlap", 32'(i_ack & d_ack), 32'h0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ack: got i_ack %0b d_ack %0b, expected none", i_ack, d_ack);
      end else begin
        mon_t = exp_q.pop_front();
        checkOutput("ack_port_d", 32'(d_ack), 32'(mon_t.is_d));
        checkOutput("rdata", rdata, mon_t.exp_rdata);
        checkOutput("err", 32'(err), 32'(mon_t.exp_err));
        checkOutput("busy_cycles", 32'(busy_seen), 32'(mon_t.exp_busy));
      end
      busy_seen = 0;
    end else if (!m_req) begin
      busy_seen = 0;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) step();
    checkOutput("reset_m_req", 32'(m_req), 32'h0);
    checkOutput("reset_acks", 32'({i_ack, d_ack}), 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);
    checkOutput("reset_rdata", rdata, 32'h0);
    rst = 1'b1;
    step();

    // Contention straight out of reset: I, D, I, D
    applyStimulus(1'b0, 1'b0, 32'h200, 32'h0,    1, 32'h11111111, 32'h11111111, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 32'h300, 32'hA5A5, 2, 32'h22222222, 32'h0,        1'b0, 2);
    applyStimulus(1'b0, 1'b0, 32'h204, 32'h0,    1, 32'h33333333, 32'h33333333, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 32'h304, 32'h0,    3, 32'h44444444, 32'h44444444, 1'b0, 3);
    waitDone(100);

    applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1);
    waitDone(50);
    step();
    checkOutput("rdata_hold", rdata, 32'hDEADBEEF);

    // Store whose m_ack lands on the would-be timeout cycle
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h55AA, 4, 32'h12345678, 32'h0, 1'b0, 4);
    waitDone(50);

    // Data request withdrawn while a fetch is in flight is never served
    applyStimulus(1'b0, 1'b0, 32'h108, 32'h0, 3, 32'h77777777, 32'h77777777, 1'b0, 3);
    step();
    d_pend.push_back('{is_d: 1'b1, we: 1'b0, addr: 32'h700, wdata: 32'h0, lat: 1,
                       mrd: 32'h0, exp_rdata: 32'h0, exp_err: 1'b0, exp_busy: 1});
    step();
    step();
    d_pend.delete();
    waitDone(50);
    repeat (3) step();
    checkOutput("withdrawn_no_access", 32'(m_req), 32'h0);

    // Hung load aborts after 4 BUSY cycles, then a normal fetch is served
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 0, 32'h0, 32'h0, 1'b1, 4);
    waitDone(50);
    applyStimulus(1'b0, 1'b0, 32'h104, 32'h0, 2, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 2);
    waitDone(50);

    // Reset in the middle of a hung fetch
    applyStimulus(1'b0, 1'b0, 32'h400, 32'h0, 0, 32'h0, 32'h0, 1'b0, 0);
    step();
    step();
    rst = 1'b0;
    i_pend.delete();
    step();
    checkOutput("abort_m_req", 32'(m_req), 32'h0);
    checkOutput("abort_acks", 32'({i_ack, d_ack}), 32'h0);
    checkOutput("abort_rdata", rdata, 32'h0);
    checkOutput("abort_err", 32'(err), 32'h0);
    exp_q.delete(0);
    rst = 1'b1;
    step();
    applyStimulus(1'b0, 1'b0, 32'h500, 32'h0, 1, 32'h55555555, 32'h55555555, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 32'h600, 32'h0, 1, 32'h66666666, 32'h66666666, 1'b0, 1);
    waitDone(50);

    // Stray m_ack while idle
    step();
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("stray_ack_m_req", 32'(m_req), 32'h0);
      checkOutput("stray_ack_acks", 32'({i_ack, d_ack}), 32'h0);
    end
    checkOutput("stray_ack_rdata", rdata, 32'h66666666);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
